// File: rtl/logic_unit_pipe_if.sv
// Streaming bus for logic_unit_pipe: input beat handshake, operation controls,
// and the registered result handshake.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       op;
  logic             acc_en;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             Y_zero;
  logic             Y_par;

  modport master (
    output in_valid, A, B, op, acc_en, acc_clr, out_ready,
    input  in_ready, out_valid, Y, Y_zero, Y_par
  );

  modport slave (
    input  in_valid, A, B, op, acc_en, acc_clr, out_ready,
    output in_ready, out_valid, Y, Y_zero, Y_par
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic ALU slice with an optional running
// accumulator that can replace operand B.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  logic_unit_pipe_if.slave bus
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;

  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] r1_q, r1_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_zero_q, y_zero_d;
  logic             y_par_q, y_par_d;

  logic             s2_adv;
  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] f_res;

  always_comb begin
    s2_adv   = v1_q && (!v2_q || bus.out_ready);
    in_ready = !v1_q || s2_adv;
    accept   = bus.in_valid && in_ready;
  end

  // acc_clr zeroes the accumulator operand for this beat, so a clear-and-use
  // beat sees 0 rather than the stale value.
  always_comb begin
    b_sel = bus.B;
    if (bus.acc_en) begin
      b_sel = bus.acc_clr ? '0 : acc_q;
    end
  end

  always_comb begin
    f_res = bus.A;
    case (bus.op)
      OP_AND:  f_res = bus.A & b_sel;
      OP_NAND: f_res = ~(bus.A & b_sel);
      OP_OR:   f_res = bus.A | b_sel;
      OP_NOR:  f_res = ~(bus.A | b_sel);
      OP_XOR:  f_res = bus.A ^ b_sel;
      OP_XNOR: f_res = ~(bus.A ^ b_sel);
      OP_NOTA: f_res = ~bus.A;
      default: f_res = bus.A;
    endcase
  end

  always_comb begin
    v1_d  = v1_q;
    r1_d  = r1_q;
    acc_d = acc_q;
    if (accept) begin
      v1_d = 1'b1;
      r1_d = f_res;
      if (bus.acc_en) begin
        acc_d = f_res;
      end else if (bus.acc_clr) begin
        acc_d = '0;
      end
    end else if (s2_adv) begin
      v1_d = 1'b0;
    end
  end

  always_comb begin
    v2_d     = v2_q;
    y_d      = y_q;
    y_zero_d = y_zero_q;
    y_par_d  = y_par_q;
    if (s2_adv) begin
      v2_d     = 1'b1;
      y_d      = r1_q;
      y_zero_d = (r1_q == '0);
      y_par_d  = ^r1_q;
    end else if (v2_q && bus.out_ready) begin
      v2_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      r1_q     <= '0;
      acc_q    <= '0;
      y_q      <= '0;
      y_zero_q <= 1'b1;
      y_par_q  <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      r1_q     <= r1_d;
      acc_q    <= acc_d;
      y_q      <= y_d;
      y_zero_q <= y_zero_d;
      y_par_q  <= y_par_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = v2_q;
  assign bus.Y         = y_q;
  assign bus.Y_zero    = y_zero_q;
  assign bus.Y_par     = y_par_q;

endmodule
